truth_table_checker: RTL

//  Self-running equivalence checker for lab combinational blocks: sweeps all
//  2^N_IN input vectors, drives them to two implementations (e.g. gate-level
//  vs operator version), compares their outputs after a settle time and

---
 rtl/truth_table_checker_pkg.sv | 10 +
 rtl/truth_table_checker_vec_sequencer.sv | 35 +++
 rtl/truth_table_checker.sv | 105 ++++++++++
 3 files changed

// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: shared FSM states and width helpers for the truth table checker
package truth_table_checker_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SAMPLE, ST_DONE} state_e;
  function automatic int tmr_w(input int h);
    return (h <= 2) ? 1 : $clog2(h);
  endfunction
  function automatic int rec_w(input int n_in, input int n_out);
    return n_in + 2 * n_out + 1;
  endfunction
endpackage

// File: rtl/truth_table_checker_vec_sequencer.sv
// tt_vec_sequencer: input-vector counter plus per-vector hold timer
module tt_vec_sequencer
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            adv_i,
  input  logic            tick_i,
  output logic [N_IN-1:0] vec_o,
  output logic            sample_now_o,
  output logic            last_vec_o
);
  localparam int TW = tmr_w(HOLD_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(HOLD_CYCLES - 1);
  logic [N_IN-1:0] vec_q;
  logic [TW-1:0]   tmr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec_q <= '0;
      tmr_q <= '0;
    end else if (load_i || adv_i) begin
      vec_q <= load_i ? '0 : vec_q + N_IN'(1);
      tmr_q <= TMAX;
    end else if (tick_i && tmr_q != '0) begin
      tmr_q <= tmr_q - TW'(1);
    end
  assign vec_o        = vec_q;
  assign sample_now_o = tmr_q == '0;
  // end of sweep is the all-ones vector, so the counter never wraps
  assign last_vec_o   = &vec_q;
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all input vectors through two implementations and compares masked outputs
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int N_OUT       = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] cmp_mask,
  input  logic [N_OUT-1:0] dut_a,
  input  logic [N_OUT-1:0] dut_b,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_ok,
  output logic             rec_valid,
  output logic [N_IN-1:0]  rec_vec,
  output logic [N_OUT-1:0] rec_a,
  output logic [N_OUT-1:0] rec_b,
  output logic             rec_match
);
  localparam int RW = rec_w(N_IN, N_OUT);
  state_e          state_q;
  logic            busy_q, done_q, pass_q, ffok_q, rv_q;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q;
  logic [RW-1:0]   rec_q;
  logic            go, mism, sample_now, last_vec, adv;
  // abort beats start when both are seen outside a sweep
  assign go    = (state_q == ST_IDLE || state_q == ST_DONE) && start && !abort;
  assign mism  = |((dut_a ^ dut_b) & cmp_mask);
  assign err_d = err_q + (N_IN + 1)'(mism);
  assign adv   = state_q == ST_SAMPLE && !abort && !last_vec;
  tt_vec_sequencer #(.N_IN(N_IN), .HOLD_CYCLES(HOLD_CYCLES)) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (go),
    .adv_i        (adv),
    .tick_i       (state_q == ST_APPLY),
    .vec_o        (vec_out),
    .sample_now_o (sample_now),
    .last_vec_o   (last_vec)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffok_q  <= 1'b0;
      rv_q    <= 1'b0;
      rec_q   <= '0;
    end else begin
      rv_q <= 1'b0;
      if (go) begin
        state_q <= ST_APPLY;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        pass_q  <= 1'b0;
        err_q   <= '0;
        ffv_q   <= '0;
        ffok_q  <= 1'b0;
      end else if (busy_q && abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else if (state_q == ST_APPLY && sample_now) begin
        state_q <= ST_SAMPLE;
      end else if (state_q == ST_SAMPLE) begin
        rv_q  <= 1'b1;
        rec_q <= {vec_out, dut_a, dut_b, !mism};
        err_q <= err_d;
        if (mism && !ffok_q) begin
          ffv_q  <= vec_out;
          ffok_q <= 1'b1;
        end
        if (last_vec) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= err_d == '0;
        end else begin
          state_q <= ST_APPLY;
        end
      end
    end
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_ok  = ffok_q;
  assign rec_valid      = rv_q;
  assign {rec_vec, rec_a, rec_b, rec_match} = rec_q;
endmodule
